// File: rtl/alu_pipe_acc.sv
// alu_pipe_acc: two-stage signed ALU with saturation, status flags and an accumulator.
// Ports: clock/i_reset; i_valid, i_dataA, i_dataB, i_sel, i_acc_clr in;
//   o_dataC, o_valid, o_overflow, o_zero, o_neg out (all registered).
module alu_pipe_acc #(
    parameter int NB_DATA  = 16,
    parameter int SATURATE = 1
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_dataA,
    input  logic [NB_DATA-1:0] i_dataB,
    input  logic [2:0]         i_sel,
    input  logic               i_acc_clr,
    output logic [NB_DATA-1:0] o_dataC,
    output logic               o_valid,
    output logic               o_overflow,
    output logic               o_zero,
    output logic               o_neg
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_ACC  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    localparam bit SAT = (SATURATE != 0);
    localparam logic [NB_DATA-1:0] MAX_VAL = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam logic [NB_DATA-1:0] MIN_VAL = {1'b1, {(NB_DATA-1){1'b0}}};
    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

    typedef struct packed {
        logic               valid;
        logic [NB_DATA-1:0] a;
        logic [NB_DATA-1:0] b;
        logic [2:0]         sel;
    } stage1_t;

    stage1_t s1;
    logic [NB_DATA-1:0] acc;

    logic [NB_DATA:0]          opX;
    logic [NB_DATA:0]          opY;
    logic [NB_DATA:0]          wide;
    logic                      wideOvf;
    logic [NB_DATA-1:0]        arith;
    logic signed [NB_DATA-1:0] shiftRaw;
    logic [NB_DATA-1:0]        shifted;
    logic [NB_DATA-1:0]        result;
    logic                      ovf;
    logic                      accOp;

    always_comb begin
        opX = {s1.a[NB_DATA-1], s1.a};
        opY = {s1.b[NB_DATA-1], s1.b};
        wide = '0;
        unique case (s1.sel)
            OP_SUB:  wide = opX - opY;
            OP_ACC:  wide = {acc[NB_DATA-1], acc} + opX;
            default: wide = opX + opY;
        endcase
        // Sign-extended sum: overflow when the two top bits disagree,
        // and the extra bit tells which direction it overflowed.
        wideOvf = wide[NB_DATA] ^ wide[NB_DATA-1];
        if (wideOvf && SAT)
            arith = wide[NB_DATA] ? MIN_VAL : MAX_VAL;
        else
            arith = wide[NB_DATA-1:0];
    end

    // Kept as a separate signed assignment so >>> stays arithmetic.
    assign shiftRaw = $signed(s1.a) >>> s1.b;

    always_comb begin
        if (s1.b >= SHIFT_LIM)
            shifted = {NB_DATA{s1.a[NB_DATA-1]}};
        else
            shifted = shiftRaw;
    end

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        accOp  = 1'b0;
        unique case (s1.sel)
            OP_ADD,
            OP_SUB: begin
                result = arith;
                ovf    = wideOvf;
            end
            OP_AND:  result = s1.a & s1.b;
            OP_OR:   result = s1.a | s1.b;
            OP_XOR:  result = s1.a ^ s1.b;
            OP_SRA:  result = shifted;
            OP_ACC: begin
                result = arith;
                ovf    = wideOvf;
                accOp  = 1'b1;
            end
            OP_LOAD: begin
                result = s1.a;
                accOp  = 1'b1;
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            s1         <= '0;
            acc        <= '0;
            o_dataC    <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            o_zero     <= 1'b0;
            o_neg      <= 1'b0;
        end else begin
            s1.valid <= i_valid;
            s1.a     <= i_dataA;
            s1.b     <= i_dataB;
            s1.sel   <= i_sel;
            o_valid  <= s1.valid;
            if (s1.valid) begin
                o_dataC    <= result;
                o_overflow <= ovf;
                o_zero     <= (result == '0);
                o_neg      <= result[NB_DATA-1];
            end
            // Clear wins over a completing acc op; that op's output
            // above was still computed from the old ACC.
            if (i_acc_clr)
                acc <= '0;
            else if (s1.valid && accOp)
                acc <= result;
        end
    end

endmodule

// File: tb/tb_alu_pipe_acc.sv
// tb_alu_pipe_acc: directed table-driven bench for alu_pipe_acc,
// one saturating and one wrapping instance fed identical stimulus.
module tb_alu_pipe_acc;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [15:0] i_dataA;
    logic [15:0] i_dataB;
    logic [2:0]  i_sel;
    logic        i_acc_clr;

    logic [15:0] sC, wC;
    logic        sV, sO, sZ, sN;
    logic        wV, wO, wZ, wN;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alu_pipe_acc #(.NB_DATA(16), .SATURATE(1)) dutSat (
        .clock(clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_dataA(i_dataA), .i_dataB(i_dataB), .i_sel(i_sel),
        .i_acc_clr(i_acc_clr), .o_dataC(sC), .o_valid(sV),
        .o_overflow(sO), .o_zero(sZ), .o_neg(sN)
    );

    alu_pipe_acc #(.NB_DATA(16), .SATURATE(0)) dutWrap (
        .clock(clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_dataA(i_dataA), .i_dataB(i_dataB), .i_sel(i_sel),
        .i_acc_clr(i_acc_clr), .o_dataC(wC), .o_valid(wV),
        .o_overflow(wO), .o_zero(wZ), .o_neg(wN)
    );

    typedef struct {
        logic        valid;
        logic        clr;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  sel;
        logic [15:0] expC;
        logic        expOvf;
        logic [15:0] expCW;
    } step_t;

    localparam int N = 26;
    step_t tab[N];

    function automatic step_t mk(input logic v, input logic clr,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] sel, input logic [15:0] c,
                                 input logic ovf, input logic [15:0] cw);
        step_t s;
        s.valid = v; s.clr = clr; s.a = a; s.b = b; s.sel = sel;
        s.expC = c; s.expOvf = ovf; s.expCW = cw;
        return s;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic clr, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] sel);
        i_valid = v; i_acc_clr = clr; i_dataA = a; i_dataB = b; i_sel = sel;
    endtask

    task automatic chkAllZero(input string name);
        chk({name, "_sC"}, 0, 32'(sC), 0);
        chk({name, "_sV"}, 0, 32'(sV), 0);
        chk({name, "_sFlags"}, 0, {29'd0, sO, sZ, sN}, 0);
        chk({name, "_wC"}, 0, 32'(wC), 0);
        chk({name, "_wV"}, 0, 32'(wV), 0);
        chk({name, "_wFlags"}, 0, {29'd0, wO, wZ, wN}, 0);
    endtask

    logic [15:0] lastS;
    logic [15:0] lastW;

    initial begin
        tab[0]  = mk(0, 0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 0, 16'h0000);
        tab[1]  = mk(1, 0, 16'hFFF1, 16'hFFF1, 3'b000, 16'hFFE2, 0, 16'hFFE2);
        tab[2]  = mk(0, 0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 0, 16'h0000);
        tab[3]  = mk(0, 0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 0, 16'h0000);
        tab[4]  = mk(1, 0, 16'hFFF1, 16'hFFF1, 3'b001, 16'h0000, 0, 16'h0000);
        tab[5]  = mk(1, 0, 16'hFFF1, 16'hFFF1, 3'b010, 16'hFFF1, 0, 16'hFFF1);
        tab[6]  = mk(1, 0, 16'hFFF1, 16'hFFF1, 3'b011, 16'hFFF1, 0, 16'hFFF1);
        tab[7]  = mk(1, 0, 16'hFFF1, 16'hFFF1, 3'b100, 16'h0000, 0, 16'h0000);
        tab[8]  = mk(1, 0, 16'h7FFF, 16'h0001, 3'b000, 16'h7FFF, 1, 16'h8000);
        tab[9]  = mk(1, 0, 16'h8000, 16'h0001, 3'b001, 16'h8000, 1, 16'h7FFF);
        tab[10] = mk(1, 0, 16'h8000, 16'd4,    3'b101, 16'hF800, 0, 16'hF800);
        tab[11] = mk(1, 0, 16'h8000, 16'd20,   3'b101, 16'hFFFF, 0, 16'hFFFF);
        tab[12] = mk(1, 0, 16'h4000, 16'd15,   3'b101, 16'h0000, 0, 16'h0000);
        tab[13] = mk(0, 1, 16'h0000, 16'h0000, 3'b000, 16'h0000, 0, 16'h0000);
        tab[14] = mk(1, 0, 16'd5,    16'h0000, 3'b110, 16'd5,    0, 16'd5);
        tab[15] = mk(1, 0, 16'd7,    16'h0000, 3'b110, 16'd12,   0, 16'd12);
        tab[16] = mk(1, 0, 16'hFFFE, 16'h0000, 3'b110, 16'd10,   0, 16'd10);
        tab[17] = mk(1, 0, 16'd100,  16'h0000, 3'b111, 16'd100,  0, 16'd100);
        tab[18] = mk(1, 0, 16'd1,    16'h0000, 3'b110, 16'd101,  0, 16'd101);
        tab[19] = mk(1, 0, 16'd5,    16'h0000, 3'b110, 16'd106,  0, 16'd106);
        tab[20] = mk(0, 1, 16'h0000, 16'h0000, 3'b000, 16'h0000, 0, 16'h0000);
        tab[21] = mk(1, 0, 16'd1,    16'h0000, 3'b110, 16'd1,    0, 16'd1);
        tab[22] = mk(1, 0, 16'h7FFF, 16'h0000, 3'b110, 16'h7FFF, 1, 16'h8000);
        tab[23] = mk(1, 0, 16'hFFFD, 16'h0000, 3'b111, 16'hFFFD, 0, 16'hFFFD);
        tab[24] = mk(1, 0, 16'hFFFF, 16'h0000, 3'b110, 16'hFFFC, 0, 16'hFFFC);
        tab[25] = mk(1, 0, 16'd5,    16'hFFFB, 3'b000, 16'h0000, 0, 16'h0000);

        i_reset = 1'b1;
        drive(0, 0, 16'h0, 16'h0, 3'b000);
        repeat (2) @(negedge clock);
        chkAllZero("reset");
        i_reset = 1'b0;
        lastS = '0;
        lastW = '0;

        for (int i = 0; i < N + 2; i++) begin
            @(negedge clock);
            if (i >= 2) begin
                automatic int k = i - 2;
                chk("sValid", k, 32'(sV), 32'(tab[k].valid));
                chk("wValid", k, 32'(wV), 32'(tab[k].valid));
                if (tab[k].valid) begin
                    lastS = tab[k].expC;
                    lastW = tab[k].expCW;
                    chk("sData", k, 32'(sC), 32'(lastS));
                    chk("sOvf", k, 32'(sO), 32'(tab[k].expOvf));
                    chk("sZero", k, 32'(sZ), 32'(lastS == 16'h0));
                    chk("sNeg", k, 32'(sN), 32'(lastS[15]));
                    chk("wData", k, 32'(wC), 32'(lastW));
                    chk("wOvf", k, 32'(wO), 32'(tab[k].expOvf));
                    chk("wZero", k, 32'(wZ), 32'(lastW == 16'h0));
                    chk("wNeg", k, 32'(wN), 32'(lastW[15]));
                end else begin
                    chk("sHold", k, 32'(sC), 32'(lastS));
                    chk("wHold", k, 32'(wC), 32'(lastW));
                end
            end
            if (i < N)
                drive(tab[i].valid, tab[i].clr, tab[i].a, tab[i].b, tab[i].sel);
            else
                drive(0, 0, 16'h0, 16'h0, 3'b000);
        end

        // Reset with two ops in flight while ACC holds 12.
        @(negedge clock);
        drive(1, 0, 16'd12, 16'h0, 3'b111);
        @(negedge clock);
        drive(1, 0, 16'd1, 16'h0, 3'b110);
        @(negedge clock);
        drive(1, 0, 16'd2, 16'd3, 3'b000);
        chk("preRstValid", 0, 32'(sV), 1);
        chk("preRstData", 0, 32'(sC), 12);
        #2;
        i_reset = 1'b1;
        i_valid = 1'b0;
        #1;
        chkAllZero("midReset");
        repeat (2) @(negedge clock);
        chkAllZero("heldReset");
        i_reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            chk("noStaleS", j, 32'(sV), 0);
            chk("noStaleW", j, 32'(wV), 0);
        end
        drive(1, 0, 16'd3, 16'h0, 3'b110);
        @(negedge clock);
        drive(0, 0, 16'h0, 16'h0, 3'b000);
        chk("postRstEarly", 0, 32'(sV), 0);
        @(negedge clock);
        chk("postRstValid", 0, 32'(sV), 1);
        chk("postRstData", 0, 32'(sC), 3);
        chk("postRstWData", 0, 32'(wC), 3);
        @(negedge clock);
        chk("postRstDrop", 0, 32'(sV), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
